// File: rtl/fft_peak_detect_if.sv
// Signal bundle for fft_peak_detect: FFT bin stream in, magnitude-squared stream and
// per-frame peak report out. The slave modport is the detector side.
interface fft_peak_detect_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 16,
  parameter int MAG_W  = 64
);
  logic signed [DATA_W-1:0] s_data_re;
  logic signed [DATA_W-1:0] s_data_im;
  logic                     s_data_valid;
  logic        [IDX_W-1:0]  s_data_user;

  logic        [MAG_W-1:0]  mag_data;
  logic                     mag_valid;
  logic        [IDX_W-1:0]  mag_user;

  logic                     peak_valid;
  logic        [IDX_W-1:0]  peak_idx;
  logic        [MAG_W-1:0]  peak_mag;
  logic        [15:0]       frame_cnt;

  modport master (
    output s_data_re, s_data_im, s_data_valid, s_data_user,
    input  mag_data, mag_valid, mag_user,
    input  peak_valid, peak_idx, peak_mag, frame_cnt
  );

  modport slave (
    input  s_data_re, s_data_im, s_data_valid, s_data_user,
    output mag_data, mag_valid, mag_user,
    output peak_valid, peak_idx, peak_mag, frame_cnt
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Magnitude-squared stream and per-frame peak finder behind the FFT core.
// Optional build macro PEAK_SKIP_DC_EN: bin 0 of each frame is excluded from the peak search.
module fft_peak_detect #(
  parameter int DATA_W = 32,
  parameter int NFFT   = 1024,
  parameter int IDX_W  = 16,
  parameter int MAG_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  fft_peak_detect_if.slave bus
);

  localparam int              CNT_W    = $clog2(NFFT);
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(NFFT - 1);

  logic signed [DATA_W-1:0]   r_s1_re;
  logic signed [DATA_W-1:0]   r_s1_im;
  logic        [IDX_W-1:0]    r_s1_user;
  logic                       r_s1_valid;

  logic signed [2*DATA_W-1:0] w_re_ext;
  logic signed [2*DATA_W-1:0] w_im_ext;
  logic signed [2*DATA_W-1:0] w_re_sq;
  logic signed [2*DATA_W-1:0] w_im_sq;

  logic        [MAG_W-1:0]    r_s2_re_sq;
  logic        [MAG_W-1:0]    r_s2_im_sq;
  logic        [IDX_W-1:0]    r_s2_user;
  logic                       r_s2_valid;
  logic        [MAG_W-1:0]    w_mag_sum;

  logic        [MAG_W-1:0]    r_mag_data;
  logic        [IDX_W-1:0]    r_mag_user;
  logic                       r_mag_valid;

  logic        [CNT_W-1:0]    r_bin_cnt;
  logic        [MAG_W-1:0]    r_max_mag;
  logic        [IDX_W-1:0]    r_max_idx;
  logic                       r_peak_valid;
  logic        [IDX_W-1:0]    r_peak_idx;
  logic        [MAG_W-1:0]    r_peak_mag;
  logic        [15:0]         r_frame_cnt;

  logic                       w_is_cand;
  logic                       w_is_seed;
  logic                       w_is_last;
  logic                       w_take;
  logic        [MAG_W-1:0]    w_best_mag;
  logic        [IDX_W-1:0]    w_best_idx;

  // S1: register the incoming beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_re    <= '0;
      r_s1_im    <= '0;
      r_s1_user  <= '0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_re    <= bus.s_data_re;
      r_s1_im    <= bus.s_data_im;
      r_s1_user  <= bus.s_data_user;
      r_s1_valid <= bus.s_data_valid;
    end
  end

  // Sign-extend before multiplying so the full 2*DATA_W product is kept.
  assign w_re_ext = {{DATA_W{r_s1_re[DATA_W-1]}}, r_s1_re};
  assign w_im_ext = {{DATA_W{r_s1_im[DATA_W-1]}}, r_s1_im};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;

  // S2: register the two squares (both non-negative).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_re_sq <= '0;
      r_s2_im_sq <= '0;
      r_s2_user  <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_re_sq <= w_re_sq;
      r_s2_im_sq <= w_im_sq;
      r_s2_user  <= r_s1_user;
      r_s2_valid <= r_s1_valid;
    end
  end

  // Each square is at most 2^(2*DATA_W-2), so the sum never exceeds 2^(2*DATA_W-1).
  assign w_mag_sum = r_s2_re_sq + r_s2_im_sq;

  // S3: magnitude-squared output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mag_data  <= '0;
      r_mag_user  <= '0;
      r_mag_valid <= 1'b0;
    end else begin
      r_mag_data  <= w_mag_sum;
      r_mag_user  <= r_s2_user;
      r_mag_valid <= r_s2_valid;
    end
  end

`ifdef PEAK_SKIP_DC_EN
  assign w_is_cand = (r_bin_cnt != {CNT_W{1'b0}});
  assign w_is_seed = (r_bin_cnt == CNT_W'(1));
`else
  assign w_is_cand = 1'b1;
  assign w_is_seed = (r_bin_cnt == {CNT_W{1'b0}});
`endif

  // Strict greater-than keeps the earliest bin on ties.
  assign w_is_last  = (r_bin_cnt == LAST_BIN);
  assign w_take     = w_is_cand & (w_is_seed | (r_mag_data > r_max_mag));
  assign w_best_mag = w_take ? r_mag_data : r_max_mag;
  assign w_best_idx = w_take ? r_mag_user : r_max_idx;

  // S4: frame framing by beat count, running max and frame-end peak report.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_cnt    <= '0;
      r_max_mag    <= '0;
      r_max_idx    <= '0;
      r_peak_valid <= 1'b0;
      r_peak_idx   <= '0;
      r_peak_mag   <= '0;
      r_frame_cnt  <= 16'd0;
    end else begin
      r_peak_valid <= 1'b0;
      if (r_mag_valid) begin
        if (w_take) begin
          r_max_mag <= r_mag_data;
          r_max_idx <= r_mag_user;
        end
        if (w_is_last) begin
          r_bin_cnt    <= '0;
          r_peak_valid <= 1'b1;
          r_peak_idx   <= w_best_idx;
          r_peak_mag   <= w_best_mag;
          r_frame_cnt  <= r_frame_cnt + 16'd1;
        end else begin
          r_bin_cnt <= r_bin_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.mag_data   = r_mag_data;
  assign bus.mag_valid  = r_mag_valid;
  assign bus.mag_user   = r_mag_user;
  assign bus.peak_valid = r_peak_valid;
  assign bus.peak_idx   = r_peak_idx;
  assign bus.peak_mag   = r_peak_mag;
  assign bus.frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Bench for fft_peak_detect (NFFT=16): directed scenarios plus random frames, checked
// against a frame-level reference model with exact latency expectations.
module tb_fft_peak_detect;
  localparam int DATA_W = 32;
  localparam int NFFT   = 16;
  localparam int IDX_W  = 16;
  localparam int MAG_W  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .MAG_W(MAG_W)) bus ();

  fft_peak_detect #(.DATA_W(DATA_W), .NFFT(NFFT), .IDX_W(IDX_W), .MAG_W(MAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    int unsigned cyc;
    logic [63:0] mag;
    logic [15:0] user;
  } exp_t;

  exp_t        mag_q[$];
  exp_t        peak_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  logic        rst_d = 1'b1;
  int          n_checks = 0;
  int          n_errors = 0;
  int          pulses = 0;
  logic [15:0] m_pidx = 16'd0;
  logic [63:0] m_pmag = 64'd0;
  logic [15:0] m_fcnt = 16'd0;
  logic [63:0] fr_mag[NFFT];
  logic [15:0] fr_usr[NFFT];
  int          pos = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endfunction

  // Monitor: outputs are compared on the falling edge against the model queues.
  always @(negedge clk) begin
    if (rst_d) begin
      mag_q.delete();
      peak_q.delete();
      m_pidx = 16'd0;
      m_pmag = 64'd0;
      m_fcnt = 16'd0;
      chk("rst_mag_valid", 64'(bus.mag_valid), 64'd0);
      chk("rst_mag_data", bus.mag_data, 64'd0);
      chk("rst_mag_user", 64'(bus.mag_user), 64'd0);
      chk("rst_peak_valid", 64'(bus.peak_valid), 64'd0);
      chk("rst_peak_idx", 64'(bus.peak_idx), 64'd0);
      chk("rst_peak_mag", bus.peak_mag, 64'd0);
      chk("rst_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    end else begin
      if (bus.mag_valid) begin
        if (mag_q.size() == 0) begin
          chk("mag_unexpected", 64'(bus.mag_valid), 64'd0);
        end else begin
          mon_e = mag_q.pop_front();
          chk("mag_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("mag_data", bus.mag_data, mon_e.mag);
          chk("mag_user", 64'(bus.mag_user), 64'(mon_e.user));
        end
      end else if (mag_q.size() != 0 && mag_q[0].cyc <= cyc) begin
        mon_e = mag_q.pop_front();
        chk("mag_missing", 64'(bus.mag_valid), 64'd1);
      end
      if (bus.peak_valid) begin
        if (peak_q.size() == 0) begin
          chk("peak_unexpected", 64'(bus.peak_valid), 64'd0);
        end else begin
          mon_e = peak_q.pop_front();
          chk("peak_cycle", 64'(cyc), 64'(mon_e.cyc));
          m_pidx = mon_e.user;
          m_pmag = mon_e.mag;
          m_fcnt = m_fcnt + 16'd1;
        end
        pulses++;
      end else if (peak_q.size() != 0 && peak_q[0].cyc <= cyc) begin
        mon_e = peak_q.pop_front();
        chk("peak_missing", 64'(bus.peak_valid), 64'd1);
      end
      chk("peak_idx_held", 64'(bus.peak_idx), 64'(m_pidx));
      chk("peak_mag_held", bus.peak_mag, m_pmag);
      chk("frame_cnt_held", 64'(bus.frame_cnt), 64'(m_fcnt));
    end
  end

  // One valid beat; the model records its magnitude and, at frame end, the frame peak.
  task automatic beat(input logic signed [31:0] re, input logic signed [31:0] im,
                      input logic [15:0] usr);
    exp_t e;
    logic signed [63:0] r64;
    logic signed [63:0] i64;
    logic [63:0] m;
    int st;
    int best;
    @(posedge clk);
    #1;
    bus.s_data_re    = re;
    bus.s_data_im    = im;
    bus.s_data_user  = usr;
    bus.s_data_valid = 1'b1;
    r64 = re;
    i64 = im;
    m = r64 * r64 + i64 * i64;
    e.cyc = cyc + 3; e.mag = m; e.user = usr;
    mag_q.push_back(e);
    fr_mag[pos] = m;
    fr_usr[pos] = usr;
    if (pos == NFFT - 1) begin
`ifdef PEAK_SKIP_DC_EN
      st = 1;
`else
      st = 0;
`endif
      best = st;
      for (int j = st + 1; j < NFFT; j++) if (fr_mag[j] > fr_mag[best]) best = j;
      e.cyc = cyc + 4; e.mag = fr_mag[best]; e.user = fr_usr[best];
      peak_q.push_back(e);
      pos = 0;
    end else begin
      pos++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.s_data_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.s_data_valid = 1'b0;
    pos = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int p0;

  initial begin
    bus.s_data_re    = 32'sd0;
    bus.s_data_im    = 32'sd0;
    bus.s_data_user  = 16'd0;
    bus.s_data_valid = 1'b0;

    // Reset held three cycles, then idle: no pulse may appear.
    do_reset(3);
    chk("t1_mag_valid", 64'(bus.mag_valid), 64'd0);
    chk("t1_peak_mag", bus.peak_mag, 64'd0);
    chk("t1_frame_cnt", 64'(bus.frame_cnt), 64'd0);
    idle(12);
    chk("t1_no_pulse", 64'(pulses), 64'd0);

    // Ramp frame with a large bin 5.
    for (int k = 0; k < NFFT; k++)
      beat((k == 5) ? 32'sd100 : 32'(k), (k == 5) ? -32'sd100 : 32'sd0, 16'(k));
    idle(6);
    chk("t2_peak_idx", 64'(bus.peak_idx), 64'd5);
    chk("t2_peak_mag", bus.peak_mag, 64'd20000);
    chk("t2_frame_cnt", 64'(bus.frame_cnt), 64'd1);

    // Tie between two worst-case bins.
    for (int k = 0; k < NFFT; k++)
      beat((k == 3 || k == 9) ? 32'sh8000_0000 : 32'sd0,
           (k == 3 || k == 9) ? 32'sh8000_0000 : 32'sd0, 16'(k));
    idle(6);
    chk("t3_peak_idx", 64'(bus.peak_idx), 64'd3);
    chk("t3_peak_mag", bus.peak_mag, 64'h8000_0000_0000_0000);
    chk("t3_frame_cnt", 64'(bus.frame_cnt), 64'd2);

    // Back-to-back frames; the second has 2-cycle gaps every 3 beats.
    for (int k = 0; k < NFFT; k++) beat(32'(3 * k), 32'(k), 16'(k));
    for (int k = 0; k < NFFT; k++) begin
      beat((k == 12) ? 32'sd500 : 32'sd7, (k == 12) ? -32'sd3 : 32'sd2, 16'(k));
      if (k % 3 == 2 && k != NFFT - 1) idle(2);
    end
    idle(6);
    chk("t4_peak_idx", 64'(bus.peak_idx), 64'd12);
    chk("t4_peak_mag", bus.peak_mag, 64'd250009);
    chk("t4_frame_cnt", 64'(bus.frame_cnt), 64'd4);
    chk("t4_pulses", 64'(pulses), 64'd4);

    // Strong DC bin versus a weaker bin 7.
    for (int k = 0; k < NFFT; k++)
      beat((k == 0) ? 32'sd1000 : ((k == 7) ? 32'sd50 : 32'sd0), 32'sd0, 16'(k));
    idle(6);
`ifdef PEAK_SKIP_DC_EN
    chk("t5_peak_idx", 64'(bus.peak_idx), 64'd7);
    chk("t5_peak_mag", bus.peak_mag, 64'd2500);
`else
    chk("t5_peak_idx", 64'(bus.peak_idx), 64'd0);
    chk("t5_peak_mag", bus.peak_mag, 64'd1000000);
`endif
    chk("t5_frame_cnt", 64'(bus.frame_cnt), 64'd5);

    // Reset aborts a partial frame; the following full frame is reported alone.
    do_reset(2);
    for (int k = 0; k < 9; k++) beat((k == 1) ? 32'sd5000 : 32'sd1, 32'sd0, 16'(k));
    do_reset(2);
    p0 = pulses;
    for (int k = 0; k < NFFT; k++) beat((k == 2) ? 32'sd300 : 32'sd1, 32'sd1, 16'(k));
    idle(8);
    chk("t6_pulses", 64'(pulses - p0), 64'd1);
    chk("t6_peak_idx", 64'(bus.peak_idx), 64'd2);
    chk("t6_peak_mag", bus.peak_mag, 64'd90001);
    chk("t6_frame_cnt", 64'(bus.frame_cnt), 64'd1);

    // Random frames: small values force ties, full-range values stress width.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < NFFT; k++) begin
        if (f % 2 == 0)
          beat(32'(int'($urandom_range(0, 6)) - 3), 32'(int'($urandom_range(0, 6)) - 3),
               16'($urandom_range(0, 65535)));
        else
          beat(32'($urandom), 32'($urandom), 16'($urandom_range(0, 65535)));
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    for (int k = 0; k < 5; k++) beat(32'($urandom), 32'($urandom), 16'(k));
    do_reset(1);
    for (int k = 0; k < NFFT; k++)
      beat(32'(int'($urandom_range(0, 4)) - 2), 32'sd0, 16'($urandom_range(0, 65535)));
    idle(8);
    chk("queues_drained", 64'(mag_q.size() + peak_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
